// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DECLEN_DEF / BINLEN_DEF : default digit count and binary operand width
//   DIGW                    : bits per BCD digit
//   state_t                 : converter FSM states (IDLE=0, SHIFT=1, DONE=2)
package bin2bcd_seq_pkg;

  localparam int unsigned DECLEN_DEF = 9;
  localparam int unsigned BINLEN_DEF = 30;
  localparam int unsigned DIGW       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble layer: add-3 correction on every BCD digit above 4
// (4-bit wrap), then a 1-bit left shift bringing bit_in into digit 0 LSB.
// Carry out of the top digit is discarded.
//   acc     : current packed BCD accumulator, digit 0 in bits [3:0]
//   bit_in  : next binary bit, MSB first
//   acc_nxt : accumulator after correction and shift
module bcd_dabble_step
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned DECLEN = DECLEN_DEF
) (
  input  logic [DECLEN*DIGW-1:0] acc,
  input  logic                   bit_in,
  output logic [DECLEN*DIGW-1:0] acc_nxt
);

  localparam int unsigned ACCW = DECLEN * DIGW;

  logic [ACCW-1:0] corr;

  always_comb begin
    corr = acc;
    for (int unsigned d = 0; d < DECLEN; d++) begin
      if (acc[d*DIGW +: DIGW] > 4'd4)
        corr[d*DIGW +: DIGW] = acc[d*DIGW +: DIGW] + 4'd3;
    end
  end

  // Shifting the whole corrected word drops its MSB (top-digit carry).
  assign acc_nxt = (corr << 1) | {{(ACCW-1){1'b0}}, bit_in};

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter. One dabble layer is reused once per
// clock for BINLEN cycles. Operands enter and results leave via valid/ready.
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : operand handshake, BIN sampled on accept
//   BIN                 : unsigned binary operand
//   out_valid/out_ready : result handshake
//   BCD                 : packed BCD result (BIN mod 10**DECLEN), digit 0 in [3:0]
//   ovf                 : operand was >= 10**DECLEN
//   busy                : conversion in progress
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned DECLEN = DECLEN_DEF,
  parameter int unsigned BINLEN = BINLEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BINLEN-1:0]      BIN,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DECLEN*DIGW-1:0] BCD,
  output logic                   ovf,
  output logic                   busy
);

  localparam int unsigned ACCW = DECLEN * DIGW;
  localparam int unsigned CNTW = $clog2(BINLEN + 1);
  // Wide enough for both the operand (+1 bit) and 10**DECLEN (< 2**ACCW).
  localparam int unsigned CMPW = (BINLEN + 1 > ACCW + 1) ? BINLEN + 1 : ACCW + 1;

  function automatic logic [CMPW-1:0] pow10(input int unsigned n);
    logic [CMPW-1:0] p;
    p = CMPW'(1);
    for (int unsigned i = 0; i < n; i++) p = p * CMPW'(10);
    return p;
  endfunction

  localparam logic [CMPW-1:0] OVF_LIMIT = pow10(DECLEN);

  state_t            state_q, state_d;
  logic [BINLEN-1:0] bin_q;
  logic [ACCW-1:0]   acc_q, acc_nxt;
  logic [CNTW-1:0]   cnt_q;
  logic              ovf_q;
  logic              load;

  bcd_dabble_step #(
    .DECLEN (DECLEN)
  ) u_step (
    .acc     (acc_q),
    .bit_in  (bin_q[BINLEN-1]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNTW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      bin_q <= BIN;
      acc_q <= '0;
      cnt_q <= CNTW'(BINLEN);
      ovf_q <= (CMPW'(BIN) >= OVF_LIMIT);
    end else if (state_q == ST_SHIFT) begin
      acc_q <= acc_nxt;
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign BCD       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results are queued on accept,
// a monitor pops and compares them when results are handed off.
module tb_bin2bcd_seq;

  localparam int unsigned DL  = 9;
  localparam int unsigned BL  = 30;
  localparam longint unsigned LIM = 64'd1000000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BL-1:0] BIN = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL*4-1:0] BCD;
  logic          ovf;
  logic          busy;

  bin2bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BIN       (BIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .BCD       (BCD),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DL*4-1:0] bcd;
    logic            ovf;
    int              acc;
    logic [BL-1:0]   bin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   or_rand = 1'b0;
  logic or_val = 1'b1;

  // Reference: decimal digits of (v mod 10**9) by repeated division.
  function automatic exp_t model(input logic [BL-1:0] v, input int acc);
    exp_t e;
    longint unsigned r;
    r = {34'd0, v};
    e.ovf = (r >= LIM);
    r = r % LIM;
    e.bcd = '0;
    for (int d = 0; d < DL; d++) begin
      e.bcd[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.acc = acc;
    e.bin = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_val;
  end

  // Monitor
  initial begin
    bit prev_take;
    bit prev_ov;
    exp_t e;
    prev_take = 1'b0;
    prev_ov   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_take = 1'b0;
        prev_ov   = 1'b0;
      end else begin
        chk("valid_ready_exclusive", {63'd0, out_valid & in_ready}, 64'd0);
        chk("busy_decode", {63'd0, busy}, {63'd0, ~out_valid & ~in_ready});
        if (prev_take) begin
          chk("idle_after_take_in_ready", {63'd0, in_ready}, 64'd1);
          chk("idle_after_take_out_valid", {63'd0, out_valid}, 64'd0);
        end
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result got BCD %0h expected none", BCD);
          end else begin
            chk("latency", 64'(cyc), 64'(sb[0].acc + int'(BL)));
          end
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("bcd_%0d", e.bin), 64'(BCD), 64'(e.bcd));
          chk($sformatf("ovf_%0d", e.bin), {63'd0, ovf}, {63'd0, e.ovf});
        end
        prev_take = out_valid & out_ready;
        prev_ov   = out_valid;
      end
    end
  end

  task automatic send(input logic [BL-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    BIN = v;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready 0 expected 1 for BIN %0d", v);
      in_valid = 1'b0;
    end else begin
      sb.push_back(model(v, cyc + 1));
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    logic [BL-1:0] v;
    logic [BL-1:0] dir [5];
    dir[0] = 30'd0;
    dir[1] = 30'd999999999;
    dir[2] = 30'd42;
    dir[3] = 30'd1000000000;
    dir[4] = 30'd1073741823;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_bcd", 64'(BCD), 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;

    or_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(dir[i]);
      drain();
    end

    // Backpressure with an ignored operand pulse
    or_val = 1'b0;
    send(30'd12345);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", {63'd0, out_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_bcd_stable", 64'(BCD), 64'h000012345);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      if (k == 1) begin
        BIN = 30'd7;
        in_valid = 1'b1;
      end
      if (k == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    or_val = 1'b1;
    drain();
    repeat (BL + 5) @(negedge clk);

    // Asynchronous reset mid-conversion
    send(30'd500);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_bcd", 64'(BCD), 64'd0);
    chk("arst_ovf", {63'd0, ovf}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_release_in_ready", {63'd0, in_ready}, 64'd1);
    send(30'd42);
    drain();

    // Randomized stream with random consumer backpressure
    or_rand = 1'b1;
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 4))
        0:       v = BL'(LIM - 1 - longint'($urandom_range(0, 3)));
        1:       v = BL'(LIM + longint'($urandom_range(0, 3)));
        2:       v = BL'($urandom_range(0, 9999));
        default: v = BL'($urandom_range(0, 32'h3FFFFFFF));
      endcase
      send(v);
    end
    drain();
    or_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
